lcd_text_arbiter: RTL and testbench

Arbitrates character writes from several requesters into the 32-byte display text buffer (2 lines × 16 characters) that feeds the LCD1602 driver. Owns the buffer's write port. Tracks which cells changed and requests a screen refresh from the driver. While the driver refreshes, the buffer is locked so the driver reads a stable image.

---
 rtl/lcd_text_arbiter.sv | 153 +++++++++++++++
 tb/tb_lcd_text_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_arbiter.sv
// lcd_text_arbiter: arbitrates requester writes into the 2x16 LCD text buffer.
// Define LCD_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module lcd_text_arbiter #(
  parameter int NREQ = 2
) (
  input  logic              C,
  input  logic              RN,
  input  logic [NREQ-1:0]   Req,
  input  logic [5*NREQ-1:0] Adr,
  input  logic [8*NREQ-1:0] Data,
  output logic [NREQ-1:0]   AckQ,
  output logic              WrEnQ,
  output logic [4:0]        WrAdrQ,
  output logic [7:0]        WrDataQ,
  output logic              UpdReqQ,
  input  logic              UpdBusy,
  input  logic              UpdDone,
  output logic [31:0]       DirtyQ
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    LOCK  = 2'd2
  } state_t;

  state_t        state;
  state_t        stateNxt;
  logic          grantVld;
  logic [IW-1:0] grantIdx;
  logic [IW-1:0] cand;
  logic          grant;
  logic [IW-1:0] winIdx;
  logic [4:0]    winAdr;
  logic [7:0]    winData;
  logic [NREQ-1:0] ackNxt;
  logic          wrEnNxt;
  logic          updReqNxt;
  logic [31:0]   dirtyNxt;

  assign grant = (state == IDLE) && !UpdBusy && grantVld;

`ifdef LCD_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest requesting index wins
  always_comb begin
    grantVld = 1'b0;
    grantIdx = '0;
    cand     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'(k);
      if (Req[cand]) begin
        grantVld = 1'b1;
        grantIdx = cand;
      end
    end
  end
`else
  logic [IW-1:0] ptr;

  // Round-robin search starting one past the last winner
  always_comb begin
    grantVld = 1'b0;
    grantIdx = '0;
    cand     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (Req[cand]) begin
        grantVld = 1'b1;
        grantIdx = cand;
      end
    end
  end

  // Last-winner pointer, moves only on a grant
  always_ff @(posedge C) begin
    if (!RN) ptr <= IW'(NREQ - 1);
    else if (grant) ptr <= grantIdx;
  end
`endif

  // State register
  always_ff @(posedge C) begin
    if (!RN) state <= IDLE;
    else     state <= stateNxt;
  end

  // Next-state logic; a refresh in progress beats a pending grant
  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE: begin
        if (UpdBusy)       stateNxt = LOCK;
        else if (grantVld) stateNxt = WRITE;
      end
      WRITE: stateNxt = IDLE;
      LOCK: begin
        if (UpdDone || !UpdBusy) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Capture the winner's address and data at the grant
  always_ff @(posedge C) begin
    if (!RN) begin
      winIdx  <= '0;
      winAdr  <= '0;
      winData <= '0;
    end else if (grant) begin
      winIdx  <= grantIdx;
      winAdr  <= Adr[5*grantIdx +: 5];
      winData <= Data[8*grantIdx +: 8];
    end
  end

  // Next output values; a request withdrawn before its ack is dropped whole
  always_comb begin
    ackNxt    = '0;
    wrEnNxt   = 1'b0;
    dirtyNxt  = DirtyQ;
    updReqNxt = (state == IDLE) && (DirtyQ != '0);
    if (state == WRITE && Req[winIdx]) begin
      wrEnNxt          = 1'b1;
      ackNxt[winIdx]   = 1'b1;
      dirtyNxt[winAdr] = 1'b1;
    end
    if (state == LOCK && UpdDone) dirtyNxt = '0;
  end

  // Output registers
  always_ff @(posedge C) begin
    if (!RN) begin
      AckQ    <= '0;
      WrEnQ   <= 1'b0;
      WrAdrQ  <= '0;
      WrDataQ <= '0;
      UpdReqQ <= 1'b0;
      DirtyQ  <= '0;
    end else begin
      AckQ    <= ackNxt;
      WrEnQ   <= wrEnNxt;
      UpdReqQ <= updReqNxt;
      DirtyQ  <= dirtyNxt;
      if (wrEnNxt) begin
        WrAdrQ  <= winAdr;
        WrDataQ <= winData;
      end
    end
  end

endmodule

// File: tb/tb_lcd_text_arbiter.sv
// tb_lcd_text_arbiter: directed and randomized checks of lcd_text_arbiter
// against a transaction-level reference model, NREQ=4.
module tb_lcd_text_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic           C = 1'b0;
  logic           RN;
  logic [N-1:0]   Req;
  logic [5*N-1:0] Adr;
  logic [8*N-1:0] Data;
  logic [N-1:0]   AckQ;
  logic           WrEnQ;
  logic [4:0]     WrAdrQ;
  logic [7:0]     WrDataQ;
  logic           UpdReqQ;
  logic           UpdBusy;
  logic           UpdDone;
  logic [31:0]    DirtyQ;

  int total = 0;
  int bad   = 0;

  always #5 C = ~C;

  lcd_text_arbiter #(.NREQ(N)) dut (
    .C       (C),
    .RN      (RN),
    .Req     (Req),
    .Adr     (Adr),
    .Data    (Data),
    .AckQ    (AckQ),
    .WrEnQ   (WrEnQ),
    .WrAdrQ  (WrAdrQ),
    .WrDataQ (WrDataQ),
    .UpdReqQ (UpdReqQ),
    .UpdBusy (UpdBusy),
    .UpdDone (UpdDone),
    .DirtyQ  (DirtyQ)
  );

  // reference model: lock flag, one pending write, last winner, dirty set
  logic         mLock;
  logic         mPend;
  int           mPIdx;
  int           mLast;
  logic [4:0]   mPAdr;
  logic [7:0]   mPData;
  logic [31:0]  mDirty;
  logic [N-1:0] eAck;
  logic         eWrEn;
  logic         eUpd;
  logic [4:0]   eAdr;
  logic [7:0]   eData;
  int           wins[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic modelEdge();
    int  cand;
    bit  found;
    if (!RN) begin
      mLock  = 1'b0;
      mPend  = 1'b0;
      mPIdx  = 0;
      mLast  = N - 1;
      mDirty = '0;
      eAck   = '0;
      eWrEn  = 1'b0;
      eUpd   = 1'b0;
      eAdr   = '0;
      eData  = '0;
    end else begin
      eUpd  = !mLock && !mPend && (mDirty != 0);
      eAck  = '0;
      eWrEn = 1'b0;
      if (mPend) begin
        if (Req[mPIdx[IW-1:0]]) begin
          eWrEn = 1'b1;
          eAck[mPIdx[IW-1:0]] = 1'b1;
          eAdr  = mPAdr;
          eData = mPData;
          mDirty[mPAdr] = 1'b1;
        end
        mPend = 1'b0;
      end else if (mLock) begin
        if (UpdDone) begin
          mDirty = '0;
          mLock  = 1'b0;
        end else if (!UpdBusy) begin
          mLock = 1'b0;
        end
      end else if (UpdBusy) begin
        mLock = 1'b1;
      end else begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
`ifdef LCD_ARB_FIXED_PRIO_EN
          cand = k - 1;
`else
          cand = (mLast + k) % N;
`endif
          if (!found && Req[cand[IW-1:0]]) begin
            found  = 1'b1;
            mPend  = 1'b1;
            mPIdx  = cand;
            mPAdr  = Adr[5*cand +: 5];
            mPData = Data[8*cand +: 8];
            mLast  = cand;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge C);
    modelEdge();
    @(negedge C);
    chk("ack",    32'(AckQ),    32'(eAck));
    chk("wren",   32'(WrEnQ),   32'(eWrEn));
    chk("wradr",  32'(WrAdrQ),  32'(eAdr));
    chk("wrdata", 32'(WrDataQ), 32'(eData));
    chk("updreq", 32'(UpdReqQ), 32'(eUpd));
    chk("dirty",  DirtyQ,       mDirty);
  endtask

  task automatic doReset();
    RN      = 1'b0;
    Req     = '0;
    UpdBusy = 1'b0;
    UpdDone = 1'b0;
    step();
    step();
    RN = 1'b1;
  endtask

  task automatic collect();
    for (int i = 0; i < N; i++)
      if (AckQ[i[IW-1:0]]) wins.push_back(i);
  endtask

  initial begin
    int busyCnt;
    busyCnt = 0;
    Adr  = '0;
    Data = '0;
    doReset();
    chk("rst_dirty",  DirtyQ,          32'h0);
    chk("rst_ack",    32'(AckQ),       32'h0);
    chk("rst_wren",   32'(WrEnQ),      32'h0);
    chk("rst_wradr",  32'(WrAdrQ),     32'h0);
    chk("rst_updreq", 32'(UpdReqQ),    32'h0);

    // single write from requester 0
    Adr[4:0]  = 5'd5;
    Data[7:0] = 8'h41;
    Req[0]    = 1'b1;
    step();
    chk("w1_early", 32'(WrEnQ), 32'h0);
    step();
    chk("w1_wren", 32'(WrEnQ),   32'h1);
    chk("w1_ack",  32'(AckQ),    32'h1);
    chk("w1_adr",  32'(WrAdrQ),  32'd5);
    chk("w1_dat",  32'(WrDataQ), 32'h41);
    Req[0] = 1'b0;
    step();
    chk("w1_dirty", DirtyQ,       32'h00000020);
    chk("w1_upd",   32'(UpdReqQ), 32'h1);

    // two requesters holding Req continuously
    doReset();
    Adr[4:0] = 5'd0;
    Adr[9:5] = 5'd16;
    Req[1:0] = 2'b11;
    wins.delete();
    repeat (8) begin
      step();
      collect();
    end
    chk("alt_cnt", 32'(wins.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < wins.size()) begin
`ifdef LCD_ARB_FIXED_PRIO_EN
        chk("alt_ord", 32'(wins[k]), 32'd0);
`else
        chk("alt_ord", 32'(wins[k]), 32'(k % 2));
`endif
      end
    end
`ifdef LCD_ARB_FIXED_PRIO_EN
    chk("alt_dirty", DirtyQ, 32'h00000001);
`else
    chk("alt_dirty", DirtyQ, 32'h00010001);
`endif
    Req = '0;
    step();
    step();

    // Req and UpdBusy together: lock first, grant after UpdDone
    Adr[4:0]  = 5'd3;
    Data[7:0] = 8'h33;
    Req[0]    = 1'b1;
    UpdBusy   = 1'b1;
    repeat (4) begin
      step();
      chk("lock_wren", 32'(WrEnQ), 32'h0);
      chk("lock_ack",  32'(AckQ),  32'h0);
    end
    UpdBusy = 1'b0;
    UpdDone = 1'b1;
    step();
    chk("done_dirty", DirtyQ, 32'h0);
    UpdDone = 1'b0;
    step();
    step();
    chk("post_ack", 32'(AckQ),   32'h1);
    chk("post_adr", 32'(WrAdrQ), 32'd3);
    Req = '0;
    step();

    // reset during the write cycle
    Adr[9:5]   = 5'd7;
    Data[15:8] = 8'h55;
    Req[1]     = 1'b1;
    step();
    RN = 1'b0;
    step();
    chk("rw_ack",    32'(AckQ),    32'h0);
    chk("rw_wren",   32'(WrEnQ),   32'h0);
    chk("rw_dirty",  DirtyQ,       32'h0);
    chk("rw_updreq", 32'(UpdReqQ), 32'h0);
    RN = 1'b1;
    step();
    step();
    chk("rw_retry_ack", 32'(AckQ),    32'h2);
    chk("rw_retry_adr", 32'(WrAdrQ),  32'd7);
    chk("rw_retry_dat", 32'(WrDataQ), 32'h55);
    Req = '0;

    // all four requesters on cell 31, each drops after its ack
    doReset();
    for (int i = 0; i < N; i++) begin
      Adr[5*i +: 5]  = 5'd31;
      Data[8*i +: 8] = 8'(8'h60 + i);
    end
    Req = '1;
    wins.delete();
    repeat (12) begin
      step();
      for (int i = 0; i < N; i++)
        if (AckQ[i[IW-1:0]]) begin
          wins.push_back(i);
          Req[i[IW-1:0]] = 1'b0;
        end
    end
    chk("all_cnt", 32'(wins.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < wins.size()) chk("all_ord", 32'(wins[k]), 32'(k));
    chk("all_dirty", DirtyQ, 32'h80000000);
    UpdDone = 1'b1;
    step();
    UpdDone = 1'b0;
    step();
    chk("idle_done_dirty", DirtyQ, 32'h80000000);

    // randomized traffic with a behavioural refresh driver
    for (int cyc = 0; cyc < 4000; cyc++) begin
      UpdDone = 1'b0;
      RN = ($urandom % 200 != 0);
      for (int i = 0; i < N; i++) begin
        if (AckQ[i[IW-1:0]] || (!Req[i[IW-1:0]] && $urandom % 4 == 0)) begin
          Req[i[IW-1:0]] = AckQ[i[IW-1:0]] ? 1'($urandom % 2) : 1'b1;
          Adr[5*i +: 5]  = 5'($urandom);
          Data[8*i +: 8] = 8'($urandom);
        end else if (Req[i[IW-1:0]] && $urandom % 40 == 0) begin
          Req[i[IW-1:0]] = 1'b0;
        end
      end
      if (busyCnt > 0) begin
        busyCnt--;
        if (busyCnt == 0) begin
          UpdBusy = 1'b0;
          UpdDone = ($urandom % 4 != 0);
        end
      end else if (UpdReqQ && $urandom % 3 == 0) begin
        UpdBusy = 1'b1;
        busyCnt = $urandom_range(1, 5);
      end else if ($urandom % 30 == 0) begin
        UpdDone = 1'b1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
